// File: rtl/spi_if.sv
// Signal bundle for the spi block: plain logic wires, no modports or clocking blocks.
interface spi_if;
  logic        clk;
  logic        rst;
  logic        newd;
  logic [11:0] din;
  logic        sclk;
  logic        cs;
  logic        mosi;
endinterface

// File: rtl/spi.sv
// SPI master transmitter: free-running sclk divider and an LSB-first shift FSM
// that advances on sclk rising edges, with cs held low for DATA_W+1 sclk periods.
module spi #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned SCLK_HALF = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic              sclk,
  output logic              cs,
  output logic              mosi
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned DivW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  typedef enum logic {StIdle, StSend} state_e;

  logic [DivW-1:0]   div_q;
  logic              sclk_q;
  logic              div_wrap;
  logic              sclk_rise;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              sel_bit;

  assign div_wrap  = (div_q == DivW'(SCLK_HALF - 1));
  // The FSM updates on the same clk edge that drives sclk high.
  assign sclk_rise = div_wrap & ~sclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (div_wrap) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + DivW'(1);
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (sclk_rise) begin
      unique case (state_q)
        StIdle:  if (newd) state_d = StSend;
        StSend:  if (bit_q == CntW'(DATA_W)) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Bit select limited to valid positions so the counter never indexes past DATA_W-1.
  always_comb begin
    sel_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (bit_q == CntW'(i)) sel_bit = shreg_q[i];
    end
  end

  // Output and datapath next values.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    if (sclk_rise) begin
      unique case (state_q)
        StIdle: begin
          if (newd) begin
            shreg_d = din;
            cs_d    = 1'b0;
            bit_d   = '0;
          end
        end
        StSend: begin
          if (bit_q < CntW'(DATA_W)) begin
            mosi_d = sel_bit;
            bit_d  = bit_q + CntW'(1);
          end else begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            bit_d  = '0;
          end
        end
        default: begin
          cs_d   = 1'b1;
          mosi_d = 1'b0;
          bit_d  = '0;
        end
      endcase
    end
  end

  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi.sv
// Self-checking bench for spi: directed stimulus with a word scoreboard that a
// receiver model fills by sampling mosi on sclk falling edges.
module tb_spi;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        newd = 1'b0;
  logic [11:0] din  = '0;
  logic        sclk;
  logic        cs;
  logic        mosi;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  spi #(
    .DATA_W   (12),
    .SCLK_HALF(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .newd(newd),
    .din (din),
    .sclk(sclk),
    .cs  (cs),
    .mosi(mosi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: skip the fall right after cs drops, then take 12 bits.
  logic        prev_sclk  = 1'b0;
  logic        prev_cs    = 1'b1;
  bit          in_xfer    = 1'b0;
  int          fall_idx   = 0;
  int          cs_low_len = 0;
  logic [11:0] rx_word    = '0;

  always @(negedge clk) begin
    if (!rst) begin
      in_xfer    = 1'b0;
      fall_idx   = 0;
      cs_low_len = 0;
    end else begin
      if (prev_cs && !cs) begin
        in_xfer    = 1'b1;
        fall_idx   = 0;
        cs_low_len = 0;
      end
      if (!cs) cs_low_len++;
      if (cs) check("mosi_idle", 32'(mosi), 32'(0));
      if (!prev_cs && cs && in_xfer) begin
        check("cs_low_len", cs_low_len, 260);
        in_xfer = 1'b0;
      end
      if (prev_sclk && !sclk && !cs && in_xfer) begin
        if (fall_idx >= 1 && fall_idx <= 12) rx_word[fall_idx-1] = mosi;
        if (fall_idx == 12) begin
          if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size() > 0), 32'(1));
          else check("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
        end
        fall_idx++;
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs;
  end

  task automatic wait_cs(input logic v, input string tag);
    int n = 0;
    while (cs !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cs), 32'(v));
  endtask

  task automatic send(input logic [11:0] w);
    din  = w;
    newd = 1'b1;
    exp_q.push_back(w);
    repeat (20) @(negedge clk);
    newd = 1'b0;
    wait_cs(1'b0, "cs_fall");
    wait_cs(1'b1, "cs_rise");
    check("end_mosi", 32'(mosi), 32'(0));
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int n;
    int lows;

    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'(0));
      check("rst_cs", 32'(cs), 32'(1));
      check("rst_mosi", 32'(mosi), 32'(0));
    end
    rst = 1'b1;

    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sclk && n < 100);
    check("first_rise_clks", n, 10);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (sclk && n < 100);
    check("sclk_high_clks", n, 10);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sclk && n < 100);
    check("sclk_low_clks", n, 10);
    @(negedge clk);

    send(12'hA5C);
    for (int i = 0; i < 4; i++) send(12'($urandom_range(0, 4095)));

    // din changes mid-transfer must not reach the wire.
    din  = 12'h001;
    newd = 1'b1;
    exp_q.push_back(12'h001);
    repeat (20) @(negedge clk);
    newd = 1'b0;
    wait_cs(1'b0, "chg_fall");
    repeat (100) @(negedge clk);
    din = 12'hFFF;
    wait_cs(1'b1, "chg_rise");
    check("chg_end_mosi", 32'(mosi), 32'(0));
    repeat (40) @(negedge clk);

    // newd held high: back-to-back transfers with one sclk period of cs high.
    din  = 12'h3C3;
    newd = 1'b1;
    exp_q.push_back(12'h3C3);
    exp_q.push_back(12'h3C3);
    wait_cs(1'b0, "b2b_fall1");
    wait_cs(1'b1, "b2b_rise1");
    n = 0;
    while (cs && n < 100) begin @(negedge clk); n++; end
    check("b2b_gap", n, 20);
    newd = 1'b0;
    wait_cs(1'b1, "b2b_rise2");
    repeat (40) @(negedge clk);

    // Reset after the 5th bit aborts the word; nothing resumes afterwards.
    din  = 12'h5A5;
    newd = 1'b1;
    wait_cs(1'b0, "abort_fall");
    newd = 1'b0;
    repeat (110) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_cs", 32'(cs), 32'(1));
    check("abort_mosi", 32'(mosi), 32'(0));
    check("abort_sclk", 32'(sclk), 32'(0));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    repeat (200) begin @(negedge clk); if (!cs) lows++; end
    check("no_resume", lows, 0);

    // A newd pulse that does not span an sclk rising edge is lost.
    n = 0;
    while (sclk && n < 40) begin @(negedge clk); n++; end
    while (!sclk && n < 80) begin @(negedge clk); n++; end
    din  = 12'h7E7;
    newd = 1'b1;
    repeat (3) @(negedge clk);
    newd = 1'b0;
    lows = 0;
    repeat (60) begin @(negedge clk); if (!cs) lows++; end
    check("short_pulse_lost", lows, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
